ccff_bitstream_loader: RTL

//  Writer side of the configuration-chain (ccff) protocol: takes bitstream words over a valid/ready

---
 rtl/ccff_bitstream_loader_if.sv | 26 ++
 rtl/ccff_bitstream_loader.sv | 129 ++++++++++++
 2 files changed

// File: rtl/ccff_bitstream_loader_if.sv
// Bitstream input stream and readback stream between a bitstream source and the loader.
interface ccff_bitstream_loader_if #(
    parameter int unsigned WORD_W = 8
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [WORD_W-1:0] rb_data;
    logic              rb_valid;

    modport master (
        output cfg_data,
        output cfg_valid,
        input  cfg_ready,
        input  rb_data,
        input  rb_valid
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready,
        output rb_data,
        output rb_valid
    );
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain writer: serializes bitstream words MSB-first onto ccff_head,
// qualifies each chain shift with ccff_shift_en and packs ccff_tail into readback words.
module ccff_bitstream_loader #(
    parameter int unsigned CHAIN_LEN = 65,
    parameter int unsigned WORD_W    = 8
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  start,
    ccff_bitstream_loader_if.slave bus,
    output logic                  ccff_head,
    output logic                  ccff_shift_en,
    input  logic                  ccff_tail,
    output logic                  busy,
    output logic                  done
);
    localparam int unsigned BCW = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WCW = $clog2(WORD_W + 1);
    localparam int unsigned CW  = ((BCW > WCW) ? BCW : WCW) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state, n_state;
    logic [BCW-1:0]    bit_cnt, n_bit;
    logic [WORD_W-1:0] buf_q, n_buf;
    logic [WCW-1:0]    buf_cnt, n_bufcnt;
    logic [WORD_W-1:0] rb_acc, n_acc;
    logic [WCW-1:0]    rb_cnt, n_rbcnt;
    logic [WORD_W-1:0] cap_word;
    logic              emit;
    logic [CW-1:0]     rem;
    logic [CW-1:0]     committed;

    // Next-state datapath: shift the buffer out, capture the tail, reload on accept.
    always_comb begin
        n_state  = state;
        n_bit    = bit_cnt;
        n_buf    = buf_q;
        n_bufcnt = buf_cnt;
        n_acc    = rb_acc;
        n_rbcnt  = rb_cnt;
        cap_word = rb_acc;
        emit     = 1'b0;
        rem      = '0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    n_state  = ST_LOAD;
                    n_bit    = '0;
                    n_buf    = '0;
                    n_bufcnt = '0;
                    n_acc    = '0;
                    n_rbcnt  = '0;
                end
            end
            ST_LOAD: begin
                if (ccff_shift_en) begin
                    n_buf    = buf_q << 1;
                    n_bufcnt = buf_cnt - WCW'(1);
                    n_bit    = bit_cnt + BCW'(1);
                    // Accumulator stays left-aligned so a final partial word has zero low bits.
                    cap_word = rb_acc | (WORD_W'(ccff_tail) << (WCW'(WORD_W - 1) - rb_cnt));
                    if ((rb_cnt == WCW'(WORD_W - 1)) || (n_bit == BCW'(CHAIN_LEN))) begin
                        emit    = 1'b1;
                        n_acc   = '0;
                        n_rbcnt = '0;
                    end else begin
                        n_acc   = cap_word;
                        n_rbcnt = rb_cnt + WCW'(1);
                    end
                    if (n_bit == BCW'(CHAIN_LEN)) begin
                        n_state = ST_DONE;
                    end
                end
                if (bus.cfg_valid && bus.cfg_ready) begin
                    // Only as many bits as the chain still needs; surplus low bits are dropped.
                    n_buf    = bus.cfg_data;
                    rem      = CW'(CHAIN_LEN) - CW'(n_bit);
                    n_bufcnt = (rem > CW'(WORD_W)) ? WCW'(WORD_W) : WCW'(rem);
                end
            end
            default: n_state = ST_IDLE;
        endcase
    end

    // Bits already shifted plus bits held: once this reaches CHAIN_LEN no further word is taken.
    assign committed = CW'(n_bit) + CW'(n_bufcnt);

    // State, datapath and registered outputs, all derived from the next-state values.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            buf_q         <= '0;
            buf_cnt       <= '0;
            rb_acc        <= '0;
            rb_cnt        <= '0;
            bus.cfg_ready <= 1'b0;
            bus.rb_data   <= '0;
            bus.rb_valid  <= 1'b0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= n_state;
            bit_cnt       <= n_bit;
            buf_q         <= n_buf;
            buf_cnt       <= n_bufcnt;
            rb_acc        <= n_acc;
            rb_cnt        <= n_rbcnt;
            // Ready with an empty buffer, or with one bit left that shifts out this cycle.
            bus.cfg_ready <= (n_state == ST_LOAD) && (committed < CW'(CHAIN_LEN)) &&
                             ((n_bufcnt == '0) || (n_bufcnt == WCW'(1)));
            bus.rb_valid  <= emit;
            if (emit) begin
                bus.rb_data <= cap_word;
            end
            ccff_head     <= n_buf[WORD_W-1];
            ccff_shift_en <= (n_state == ST_LOAD) && (n_bufcnt != '0);
            busy          <= (n_state == ST_LOAD);
            done          <= (n_state == ST_DONE);
        end
    end
endmodule
